// File: rtl/coin_input_conditioner.sv
// Coin-slot front end: synchronises and debounces three raw sensor lines, then issues
// one-cycle coin pulses by fixed priority. Also raises per-slot jam flags and a sticky overrun flag.
module coin_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned JAM_CYCLES      = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       nickle_raw_i,
  input  logic       dime_raw_i,
  input  logic       quarter_raw_i,
  output logic       nickle_o,
  output logic       dime_o,
  output logic       quarter_o,
  output logic [2:0] jam_o,
  output logic       overrun_o
);

  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned JW  = $clog2(JAM_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [JW-1:0] JAM_MAX  = JW'(JAM_CYCLES);

  logic [NCH-1:0] raw_c;
  logic [NCH-1:0] sync1, sync2;
  logic [NCH-1:0] db, db_nxt;
  logic [CW-1:0]  cnt [NCH];
  logic [CW-1:0]  cnt_nxt [NCH];
  logic [JW-1:0]  jcnt [NCH];
  logic [JW-1:0]  jcnt_nxt [NCH];
  logic [NCH-1:0] jam_nxt;
  logic [NCH-1:0] pend, pend_nxt;
  logic [NCH-1:0] rise_c, grant_c;
  logic           ovr_nxt;

  assign raw_c = {quarter_raw_i, dime_raw_i, nickle_raw_i};

  // Debounce, jam counting, rise detection and priority issue
  always_comb begin
    db_nxt   = db;
    jam_nxt  = '0;
    grant_c  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      cnt_nxt[ch]  = '0;
      jcnt_nxt[ch] = '0;
      if (sync2[ch] != db[ch]) begin
        if (cnt[ch] == CNT_LAST) begin
          db_nxt[ch] = sync2[ch];
        end else begin
          cnt_nxt[ch] = cnt[ch] + CW'(1);
        end
      end
      if (db[ch]) begin
        jcnt_nxt[ch] = (jcnt[ch] == JAM_MAX) ? jcnt[ch] : jcnt[ch] + JW'(1);
        jam_nxt[ch]  = (jcnt_nxt[ch] == JAM_MAX);
      end
    end
    rise_c = db_nxt & ~db;
    if (pend[2]) begin
      grant_c = 3'b100;
    end else if (pend[1]) begin
      grant_c = 3'b010;
    end else if (pend[0]) begin
      grant_c = 3'b001;
    end
    // A rise on a slot whose coin is issued this cycle replaces it rather than overrunning
    pend_nxt = (pend & ~grant_c) | rise_c;
    ovr_nxt  = overrun_o | (|(rise_c & pend & ~grant_c));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1     <= '0;
      sync2     <= '0;
      db        <= '0;
      pend      <= '0;
      jam_o     <= '0;
      overrun_o <= 1'b0;
      nickle_o  <= 1'b0;
      dime_o    <= 1'b0;
      quarter_o <= 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        cnt[ch]  <= '0;
        jcnt[ch] <= '0;
      end
    end else begin
      sync1     <= raw_c;
      sync2     <= sync1;
      db        <= db_nxt;
      pend      <= pend_nxt;
      jam_o     <= jam_nxt;
      overrun_o <= ovr_nxt;
      nickle_o  <= grant_c[0];
      dime_o    <= grant_c[1];
      quarter_o <= grant_c[2];
      for (int ch = 0; ch < NCH; ch++) begin
        cnt[ch]  <= cnt_nxt[ch];
        jcnt[ch] <= jcnt_nxt[ch];
      end
    end
  end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner: two instances (default-ish and fast debounce) checked
// every cycle against a history-window reference model, plus directed scenario checks.
module tb_coin_input_conditioner;

  localparam int DB0  = 4;
  localparam int JAM0 = 16;
  localparam int DB1  = 1;
  localparam int JAM1 = 3;
  localparam int HMAX = 6;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [2:0] raw0, raw1;
  logic       n0, d0, q0, ovr0, n1, d1, q1, ovr1;
  logic [2:0] jam0, jam1;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state, index = unit
  logic [2:0] hist [2][HMAX];
  int         hcnt [2];
  int         edge_n [2];
  int         rise_at [2][3];
  logic [2:0] m_db [2];
  logic [2:0] m_pend [2];
  logic [2:0] m_out [2];
  logic [2:0] m_jam [2];
  logic       m_ovr [2];

  int cnt_a, cnt_b, at_a, at_b, both, jfirst, jlast;
  logic [2:0] lvl [2];
  int run [2][3];

  always #5 clk_i = ~clk_i;

  coin_input_conditioner #(.DEBOUNCE_CYCLES(DB0), .JAM_CYCLES(JAM0)) u_dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .nickle_raw_i(raw0[0]), .dime_raw_i(raw0[1]), .quarter_raw_i(raw0[2]),
    .nickle_o(n0), .dime_o(d0), .quarter_o(q0), .jam_o(jam0), .overrun_o(ovr0)
  );

  coin_input_conditioner #(.DEBOUNCE_CYCLES(DB1), .JAM_CYCLES(JAM1)) u_dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .nickle_raw_i(raw1[0]), .dime_raw_i(raw1[1]), .quarter_raw_i(raw1[2]),
    .nickle_o(n1), .dime_o(d1), .quarter_o(q1), .jam_o(jam1), .overrun_o(ovr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      hcnt[u] = 0; edge_n[u] = 0;
      m_db[u] = '0; m_pend[u] = '0; m_out[u] = '0; m_jam[u] = '0; m_ovr[u] = 1'b0;
      for (int i = 0; i < HMAX; i++) hist[u][i] = '0;
      for (int ch = 0; ch < 3; ch++) rise_at[u][ch] = 0;
    end
  endtask

  // Level flips once the last N synchronised samples all disagree with it
  task automatic model_edge(input int u, input logic [2:0] r);
    int dbn, jamn;
    logic [2:0] grant, rise, jnew;
    logic all_m;
    dbn  = (u == 0) ? DB0 : DB1;
    jamn = (u == 0) ? JAM0 : JAM1;
    edge_n[u]++;
    for (int i = HMAX - 1; i > 0; i--) hist[u][i] = hist[u][i-1];
    hist[u][0] = r;
    if (hcnt[u] < HMAX) hcnt[u]++;
    grant = 3'b000;
    for (int ch = 0; ch < 3; ch++) if (m_pend[u][ch]) grant = 3'(1 << ch);
    rise = 3'b000;
    jnew = 3'b000;
    for (int ch = 0; ch < 3; ch++) begin
      jnew[ch] = m_db[u][ch] && (edge_n[u] - rise_at[u][ch] >= jamn);
      all_m = (hcnt[u] >= dbn + 2);
      for (int i = 2; i < dbn + 2; i++) if (hist[u][i][ch] == m_db[u][ch]) all_m = 1'b0;
      if (all_m) begin
        m_db[u][ch] = ~m_db[u][ch];
        if (m_db[u][ch]) begin
          rise[ch] = 1'b1;
          rise_at[u][ch] = edge_n[u];
        end
      end
    end
    if ((rise & m_pend[u] & ~grant) != 3'b000) m_ovr[u] = 1'b1;
    m_pend[u] = (m_pend[u] & ~grant) | rise;
    m_out[u]  = grant;
    m_jam[u]  = jnew;
  endtask

  task automatic check_all();
    chk("u0_coins",   32'({q0, d0, n0}), 32'(m_out[0]));
    chk("u0_jam",     32'(jam0),         32'(m_jam[0]));
    chk("u0_overrun", 32'(ovr0),         32'(m_ovr[0]));
    chk("u1_coins",   32'({q1, d1, n1}), 32'(m_out[1]));
    chk("u1_jam",     32'(jam1),         32'(m_jam[1]));
    chk("u1_overrun", 32'(ovr1),         32'(m_ovr[1]));
  endtask

  task automatic step(input logic [2:0] r0, input logic [2:0] r1);
    raw0 = r0;
    raw1 = r1;
    @(posedge clk_i);
    model_edge(0, r0);
    model_edge(1, r1);
    #1;
    check_all();
  endtask

  initial begin
    rst_ni = 1'b0; raw0 = '0; raw1 = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_u0", 32'({q0, d0, n0, jam0, ovr0}), 32'd0);
    chk("reset_u1", 32'({q1, d1, n1, jam1, ovr1}), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // clean nickel, 10 cycles
    cnt_a = 0; at_a = 0;
    for (int i = 1; i <= 20; i++) begin
      step((i <= 10) ? 3'b001 : 3'b000, 3'b000);
      if (n0) begin cnt_a++; at_a = i; end
    end
    chk("t1_pulses", 32'(cnt_a), 32'd1);
    chk("t1_latency", 32'(at_a), 32'd7);

    // bouncing dime then held high; last transition at step 13
    cnt_a = 0; at_a = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i <= 12) step((((i - 1) / 2) % 2 == 0) ? 3'b010 : 3'b000, 3'b000);
      else step((i <= 24) ? 3'b010 : 3'b000, 3'b000);
      if (d0) begin cnt_a++; at_a = i; end
    end
    chk("t2_pulses", 32'(cnt_a), 32'd1);
    chk("t2_latency", 32'(at_a), 32'd19);

    // quarter and dime together
    at_a = 0; at_b = 0; both = 0; cnt_a = 0;
    for (int i = 1; i <= 20; i++) begin
      step((i <= 8) ? 3'b110 : 3'b000, 3'b000);
      if (q0) begin at_a = i; cnt_a++; end
      if (d0) begin at_b = i; cnt_a++; end
      if (q0 && d0) both++;
    end
    chk("t3_q_cycle", 32'(at_a), 32'd7);
    chk("t3_d_cycle", 32'(at_b), 32'd8);
    chk("t3_both_high", 32'(both), 32'd0);
    chk("t3_pulses", 32'(cnt_a), 32'd2);

    // nickel jammed high for 40 cycles
    cnt_a = 0; cnt_b = 0; jfirst = 0; jlast = 0;
    for (int i = 1; i <= 60; i++) begin
      step((i <= 40) ? 3'b001 : 3'b000, 3'b000);
      if (n0) cnt_a++;
      if (jam0 == 3'b001) begin
        cnt_b++;
        if (jfirst == 0) jfirst = i;
        jlast = i;
      end
    end
    chk("t4_pulses", 32'(cnt_a), 32'd1);
    chk("t4_jam_first", 32'(jfirst), 32'd22);
    chk("t4_jam_last", 32'(jlast), 32'd46);
    chk("t4_jam_cycles", 32'(cnt_b), 32'd25);

    // 3-cycle glitch is rejected
    cnt_a = 0;
    for (int i = 1; i <= 15; i++) begin
      step((i <= 3) ? 3'b001 : 3'b000, 3'b000);
      if (n0 || d0 || q0) cnt_a++;
    end
    chk("t5_glitch_pulses", 32'(cnt_a), 32'd0);

    // fast-debounce unit: nickel re-rises while still waiting behind quarter and dime
    chk("t5_ovr_before", 32'(ovr1), 32'd0);
    step(3'b000, 3'b101);
    step(3'b000, 3'b110);
    for (int i = 0; i < 4; i++) step(3'b000, 3'b111);
    chk("t5_ovr_set", 32'(ovr1), 32'd1);
    for (int i = 0; i < 12; i++) step(3'b000, 3'b000);
    chk("t5_ovr_sticky", 32'(ovr1), 32'd1);

    // asynchronous reset with coins still pending
    for (int i = 1; i <= 7; i++) step(3'b111, 3'b000);
    chk("t6_pre_reset_q", 32'(q0), 32'd1);
    rst_ni = 1'b0; raw0 = '0; raw1 = '0;
    #1;
    chk("t6_async_u0", 32'({q0, d0, n0, jam0, ovr0}), 32'd0);
    chk("t6_async_u1", 32'({q1, d1, n1, jam1, ovr1}), 32'd0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cnt_a = 0;
    for (int i = 1; i <= 20; i++) begin
      step(3'b000, 3'b000);
      if (n0 || d0 || q0 || n1 || d1 || q1) cnt_a++;
    end
    chk("t6_no_pulse", 32'(cnt_a), 32'd0);

    // randomised bouncing on every line of both units
    for (int u = 0; u < 2; u++) begin
      lvl[u] = '0;
      for (int ch = 0; ch < 3; ch++) run[u][ch] = 0;
    end
    for (int s = 0; s < 600; s++) begin
      for (int u = 0; u < 2; u++) begin
        for (int ch = 0; ch < 3; ch++) begin
          if (run[u][ch] == 0) begin
            lvl[u][ch] = ~lvl[u][ch];
            if (u == 0) run[u][ch] = ($urandom_range(0, 7) == 0) ? 30 : int'($urandom_range(1, 8));
            else run[u][ch] = int'($urandom_range(1, 4));
          end
          run[u][ch]--;
        end
      end
      step(lvl[0], lvl[1]);
    end
    for (int i = 0; i < 40; i++) step(3'b000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
